ex_mdu: RTL
===========

Name: ex_mdu

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, living inside the EX stage.
- Executes MULT, MULTU, DIV, DIVU (one bit per cycle, shift-add multiply, restoring divide), plus single-cycle MTHI/MTLO.
- Raises stallreq toward the pipeline stall controller while an operation is in flight.
- Accepts a flush cancel from the controller.

Parameters:
- DATA_W, 32: operand, HI and LO width. Must be at least 2.
- CNT_W, $clog2(DATA_W): width of the iteration counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cancel  in  1  flush; aborts any in-flight operation
- op_valid  in  1  EX holds a valid MDU op
- op  in  3  operation code (encodings in shared header)
- src_a  in  DATA_W  multiplicand / dividend / MTHI-MTLO data
- src_b  in  DATA_W  multiplier / divisor
- stallreq  out  1  freeze IF..EX this cycle
- busy  out  1  state is BUSY
- done  out  1  one-cycle pulse; HI/LO written at the end of this cycle
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset: state=IDLE; hi, lo, counter and internal registers = 0; stallreq, busy, done = 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - On op_valid with op in {MULT, MULTU, DIV, DIVU}: stallreq=1 combinationally; latch |src_a| and |src_b| (absolute value for signed ops, raw for unsigned); record the result signs; counter=0; go to BUSY.
  - Exception: DIV/DIVU with src_b==0 goes directly to DONE with quotient=all ones and remainder=src_a.
- BUSY:
  - stallreq=1, busy=1.
  - Each cycle performs one iteration.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper half of a 2*DATA_W accumulator, then shift right 1.
  - Divide: shift the remainder/quotient pair left 1, trial-subtract the divisor, and restore if negative.
  - When counter==DATA_W-1, go to DONE; otherwise counter+1.
- DONE:
  - stallreq=0, done=1.
  - Apply sign correction:
    - Product is negated if the operand signs differ.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(dividend).
  - At the end of the cycle: HI=product[2W-1:W] or remainder; LO=product[W-1:0] or quotient.
  - Then go to IDLE unconditionally. A start in DONE is ignored, because the pipeline advances this cycle.
- Latency: accept at cycle 0, BUSY for cycles 1..DATA_W, DONE at cycle DATA_W+1.
  - stallreq is high for DATA_W+1 cycles.
  - New HI/LO is visible at cycle DATA_W+2.
  - For divide-by-zero: stallreq for 1 cycle, done at cycle 1.
- MTHI/MTLO:
  - Act only in IDLE with op_valid.
  - Write HI (resp. LO) = src_a at the end of the cycle.
  - No stallreq and no done.
- op NONE or op_valid=0: no effect.
- Signed overflow (-2^(W-1) / -1): quotient=0x80000000, remainder=0. No trap.
- cancel:
  - Highest priority after rst.
  - From any state: go to IDLE next cycle, no HI/LO write, done=0 that cycle.
  - stallreq is forced to 0 while cancel=1.
- op_valid/op/src changes while BUSY are ignored, since operands were latched.

Decomposition:
- Shared header lib/defines.vh defines:
  - MDU_OP_W=3.
  - Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - MDU_IDLE/BUSY/DONE state encodings.
- One sub-module, mdu_iter. It holds the iteration datapath: accumulator or remainder/quotient register with a mode select, one step per enable. ex_mdu keeps the FSM, sign handling and HI/LO.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> stallreq high 33 cycles, done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 0x80000000/0xFFFFFFFF -> LO=0, HI=0x80000000. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> done at cycle 1, LO=0xFFFFFFFF, HI=0x00000005, stallreq for 1 cycle only.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> no stallreq; hi/lo show the values one cycle after each write.
- Start MULT with HI=LO=0x11111111 and cancel at cycle 10 -> stallreq=0 from cycle 10, state IDLE at cycle 11, no done, HI/LO unchanged. Repeat with rst at cycle 10 -> all outputs 0.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and small op-decoding helpers.
package ex_mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_OP_NONE  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_muldiv(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/ex_mdu_iter.sv
// One-bit-per-step datapath: shift-add multiply or restoring divide on unsigned
// magnitudes held in a single 2*DATA_W accumulator.
module mdu_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_div,
  input  logic [DATA_W-1:0]     i_init,
  input  logic [DATA_W-1:0]     i_opb,
  output logic [2*DATA_W-1:0]   o_acc
);

  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opb;
  logic                r_div;

  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W+1:0]   w_diff;
  logic [2*DATA_W-1:0] w_div_next;

  // Multiply: lower half holds the multiplier being consumed LSB first; the
  // carry out of the upper-half add re-enters as the new MSB on the shift.
  assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[DATA_W-1:1]}
                               : {1'b0, r_acc[2*DATA_W-1:1]};

  // Divide: the shifted partial remainder needs DATA_W+1 bits, and the trial
  // subtraction one more for its sign; lower half collects quotient bits.
  assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opb};
  assign w_div_next = w_diff[DATA_W+1]
                    ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                    : {w_diff[DATA_W-1:0],   r_acc[DATA_W-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_opb <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_acc <= {{DATA_W{1'b0}}, i_init};
      r_opb <= i_opb;
      r_div <= i_div;
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: FSM, operand sign handling, stall request and
// the architectural HI/LO registers around the iterative datapath.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cancel,
  input  logic                op_valid,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  output logic                stallreq,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [1:0]          dbg_state
);

  mdu_state_e          r_state;
  mdu_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_div;
  logic                r_dz;
  logic [DATA_W-1:0]   r_dz_a;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_is_div;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_a_abs;
  logic [DATA_W-1:0]   w_b_abs;
  logic                w_start;
  logic                w_dz;
  logic                w_step;
  logic                w_mt_ok;
  logic [2*DATA_W-1:0] w_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_q;
  logic [DATA_W-1:0]   w_r;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;

  assign w_is_div = op_is_div(op);
  assign w_a_neg  = op_is_signed(op) & src_a[DATA_W-1];
  assign w_b_neg  = op_is_signed(op) & src_b[DATA_W-1];
  assign w_a_abs  = w_a_neg ? -src_a : src_a;
  assign w_b_abs  = w_b_neg ? -src_b : src_b;
  assign w_dz     = w_is_div & (src_b == '0);
  assign w_start  = (r_state == MDU_IDLE) & op_valid & op_is_muldiv(op) & ~cancel;
  assign w_step   = (r_state == MDU_BUSY) & ~cancel;
  assign w_mt_ok  = (r_state == MDU_IDLE) & op_valid & ~cancel;

  mdu_iter #(.DATA_W(DATA_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start & ~w_dz),
    .i_step (w_step),
    .i_div  (w_is_div),
    .i_init (w_is_div ? w_a_abs : w_b_abs),
    .i_opb  (w_is_div ? w_b_abs : w_a_abs),
    .o_acc  (w_acc)
  );

  always_comb begin
    w_state_nxt = r_state;
    stallreq    = 1'b0;
    done        = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (w_start) begin
          stallreq    = 1'b1;
          w_state_nxt = w_dz ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        stallreq = 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = MDU_DONE;
      end
      MDU_DONE: begin
        done        = 1'b1;
        w_state_nxt = MDU_IDLE;
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
    if (cancel) begin
      w_state_nxt = MDU_IDLE;
      stallreq    = 1'b0;
      done        = 1'b0;
    end
  end

  // Magnitude results get their signs back here; a zero divisor bypasses the
  // datapath entirely and reports the raw dividend as remainder.
  assign w_prod   = r_neg_res ? -w_acc : w_acc;
  assign w_q      = w_acc[DATA_W-1:0];
  assign w_r      = w_acc[2*DATA_W-1:DATA_W];
  assign w_res_hi = r_dz  ? r_dz_a
                  : r_div ? (r_neg_rem ? -w_r : w_r)
                  : w_prod[2*DATA_W-1:DATA_W];
  assign w_res_lo = r_dz  ? {DATA_W{1'b1}}
                  : r_div ? (r_neg_res ? -w_q : w_q)
                  : w_prod[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MDU_IDLE;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div     <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_a    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_div     <= w_is_div;
        r_dz      <= w_dz;
        r_dz_a    <= src_a;
        r_cnt     <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_ok && op == MDU_OP_MTHI) begin
        r_hi <= src_a;
      end else if (w_mt_ok && op == MDU_OP_MTLO) begin
        r_lo <= src_a;
      end
    end
  end

  assign busy      = (r_state == MDU_BUSY);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule
